// File: rtl/rv32_pkg.sv
// Shared RV32I encodings for the execute stage: ALU op codes, branch types,
// writeback selects and the forwarding match helper.
package rv32_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [2:0] BR_EQ   = 3'd0;
    localparam logic [2:0] BR_NE   = 3'd1;
    localparam logic [2:0] BR_NONE = 3'd2;
    localparam logic [2:0] BR_JUMP = 3'd3;
    localparam logic [2:0] BR_LT   = 3'd4;
    localparam logic [2:0] BR_GE   = 3'd5;
    localparam logic [2:0] BR_LTU  = 3'd6;
    localparam logic [2:0] BR_GEU  = 3'd7;

    localparam logic [1:0] WB_PC4 = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;

    // x0 is hardwired to zero, so it never matches a producer.
    function automatic logic fwd_match(input logic [4:0] src, input logic [4:0] rd,
                                       input logic wr);
        return wr && (rd != 5'd0) && (src == rd);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Execute-stage bus: D/E operands and control in, writeback bypass in,
// redirect and E/M pipeline register out.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    // stall_M=1 means the memory stage is not accepting: the E/M register
    // holds its contents and no redirect may be issued from E.
    logic            stall_M;
    logic [3:0]      alu_op_E;
    logic            reg_wr_E;
    logic            sel_A_E;
    logic            sel_B_E;
    logic [2:0]      wr_en_E;
    logic [2:0]      rd_en_E;
    logic [1:0]      wb_sel_E;
    logic [2:0]      br_type_E;
    logic [XLEN-1:0] pc_E;
    logic [XLEN-1:0] rs1_data_E;
    logic [XLEN-1:0] rs2_data_E;
    logic [XLEN-1:0] imm_E;
    logic [4:0]      rs1_E;
    logic [4:0]      rs2_E;
    logic [4:0]      rd_E;
    logic [4:0]      rd_W;
    logic            reg_wr_W;
    logic [XLEN-1:0] wb_data_W;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] alu_result_M;
    logic [XLEN-1:0] store_data_M;
    logic [XLEN-1:0] pc_M;
    logic [4:0]      rd_M;
    logic            reg_wr_M;
    logic [2:0]      wr_en_M;
    logic [2:0]      rd_en_M;
    logic [1:0]      wb_sel_M;

    modport master (
        output stall_M, alu_op_E, reg_wr_E, sel_A_E, sel_B_E, wr_en_E, rd_en_E,
               wb_sel_E, br_type_E, pc_E, rs1_data_E, rs2_data_E, imm_E,
               rs1_E, rs2_E, rd_E, rd_W, reg_wr_W, wb_data_W,
        input  br_taken, br_target, alu_result_M, store_data_M, pc_M, rd_M,
               reg_wr_M, wr_en_M, rd_en_M, wb_sel_M
    );

    modport slave (
        input  stall_M, alu_op_E, reg_wr_E, sel_A_E, sel_B_E, wr_en_E, rd_en_E,
               wb_sel_E, br_type_E, pc_E, rs1_data_E, rs2_data_E, imm_E,
               rs1_E, rs2_E, rd_E, rd_W, reg_wr_W, wb_data_W,
        output br_taken, br_target, alu_result_M, store_data_M, pc_M, rd_M,
               reg_wr_M, wr_en_M, rd_en_M, wb_sel_M
    );

endinterface

// File: rtl/rv32_alu.sv
// Combinational RV32I ALU; shift amount is b[4:0], unused op codes give 0.
module rv32_alu
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_SLL:    result = a << b[4:0];
            ALU_SLT:    result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:   result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:    result = a ^ b;
            ALU_SRL:    result = a >> b[4:0];
            ALU_SRA:    result = $signed(a) >>> b[4:0];
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: M/W forwarding, ALU, branch resolution and the E/M
// register. Define EX_PERF_CNT_EN to add branch/taken event counters.
module ex_stage
    import rv32_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0] branch_cnt,
    output logic [31:0] taken_cnt
`endif
);

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic            m_fwd_ok;
    logic            br_cond;

    // A load in M has no data yet; its consumer is stalled upstream.
    assign m_fwd_ok = bus.reg_wr_M && (bus.wb_sel_M != WB_MEM);

    always_comb begin
        fwd_rs1 = bus.rs1_data_E;
        if (fwd_match(bus.rs1_E, bus.rd_M, m_fwd_ok))
            fwd_rs1 = bus.alu_result_M;
        else if (fwd_match(bus.rs1_E, bus.rd_W, bus.reg_wr_W))
            fwd_rs1 = bus.wb_data_W;
    end

    always_comb begin
        fwd_rs2 = bus.rs2_data_E;
        if (fwd_match(bus.rs2_E, bus.rd_M, m_fwd_ok))
            fwd_rs2 = bus.alu_result_M;
        else if (fwd_match(bus.rs2_E, bus.rd_W, bus.reg_wr_W))
            fwd_rs2 = bus.wb_data_W;
    end

    assign op_a = bus.sel_A_E ? fwd_rs1 : bus.pc_E;
    assign op_b = bus.sel_B_E ? bus.imm_E : fwd_rs2;

    rv32_alu #(.XLEN(XLEN)) u_alu (
        .op     (bus.alu_op_E),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result)
    );

    always_comb begin
        br_cond = 1'b0;
        case (bus.br_type_E)
            BR_EQ:   br_cond = (fwd_rs1 == fwd_rs2);
            BR_NE:   br_cond = (fwd_rs1 != fwd_rs2);
            BR_NONE: br_cond = 1'b0;
            BR_JUMP: br_cond = 1'b1;
            BR_LT:   br_cond = ($signed(fwd_rs1) < $signed(fwd_rs2));
            BR_GE:   br_cond = ($signed(fwd_rs1) >= $signed(fwd_rs2));
            BR_LTU:  br_cond = (fwd_rs1 < fwd_rs2);
            BR_GEU:  br_cond = (fwd_rs1 >= fwd_rs2);
            default: br_cond = 1'b0;
        endcase
    end

    // A held E instruction will be presented again, so it must not redirect yet.
    assign bus.br_taken  = br_cond && !rst && !bus.stall_M;
    assign bus.br_target = {alu_result[XLEN-1:1], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.alu_result_M <= '0;
            bus.store_data_M <= '0;
            bus.pc_M         <= RESET_PC;
            bus.rd_M         <= '0;
            bus.reg_wr_M     <= 1'b0;
            bus.wr_en_M      <= '0;
            bus.rd_en_M      <= '0;
            bus.wb_sel_M     <= WB_ALU;
        end else if (!bus.stall_M) begin
            bus.alu_result_M <= alu_result;
            bus.store_data_M <= fwd_rs2;
            bus.pc_M         <= bus.pc_E;
            bus.rd_M         <= bus.rd_E;
            bus.reg_wr_M     <= bus.reg_wr_E;
            bus.wr_en_M      <= bus.wr_en_E;
            bus.rd_en_M      <= bus.rd_en_E;
            bus.wb_sel_M     <= bus.wb_sel_E;
        end
    end

`ifdef EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            if (!bus.stall_M && (bus.br_type_E != BR_NONE) && (bus.br_type_E != BR_JUMP))
                branch_cnt <= branch_cnt + 32'd1;
            if (bus.br_taken)
                taken_cnt <= taken_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: driver pushes the expected E/M contents per
// cycle, a monitor pops and compares after every rising edge.
module tb_ex_stage;
    import rv32_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] store;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        reg_wr;
        logic [2:0]  wr_en;
        logic [2:0]  rd_en;
        logic [1:0]  wb_sel;
    } em_t;

    localparam em_t EM_RST = '{alu: 32'h0, store: 32'h0, pc: RST_PC, rd: 5'd0,
                               reg_wr: 1'b0, wr_en: 3'd0, rd_en: 3'd0, wb_sel: 2'd1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_branch_cnt = 0;
    int   exp_taken_cnt = 0;
    em_t  exp_q[$];
    em_t  last_exp;

    ex_stage_if #(.XLEN(32)) bus ();

`ifdef EX_PERF_CNT_EN
    logic [31:0] branch_cnt;
    logic [31:0] taken_cnt;
`endif

    ex_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef EX_PERF_CNT_EN
        ,
        .branch_cnt (branch_cnt),
        .taken_cnt  (taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the E/M register updates (or holds) on every edge.
    always @(posedge clk) begin
        em_t act;
        em_t exp;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = '{alu: bus.alu_result_M, store: bus.store_data_M, pc: bus.pc_M,
                    rd: bus.rd_M, reg_wr: bus.reg_wr_M, wr_en: bus.wr_en_M,
                    rd_en: bus.rd_en_M, wb_sel: bus.wb_sel_M};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL em_reg @%0t: got alu=%h st=%h pc=%h rd=%0d rw=%b we=%0d re=%0d wb=%0d expected alu=%h st=%h pc=%h rd=%0d rw=%b we=%0d re=%0d wb=%0d",
                         $time, act.alu, act.store, act.pc, act.rd, act.reg_wr, act.wr_en,
                         act.rd_en, act.wb_sel, exp.alu, exp.store, exp.pc, exp.rd,
                         exp.reg_wr, exp.wr_en, exp.rd_en, exp.wb_sel);
            end
        end
    end

    task automatic bubble();
        bus.alu_op_E   = ALU_ADD;
        bus.reg_wr_E   = 1'b0;
        bus.sel_A_E    = 1'b0;
        bus.sel_B_E    = 1'b1;
        bus.wr_en_E    = 3'd0;
        bus.rd_en_E    = 3'd0;
        bus.wb_sel_E   = WB_ALU;
        bus.br_type_E  = BR_NONE;
        bus.rs1_data_E = 32'h0;
        bus.rs2_data_E = 32'h0;
        bus.imm_E      = 32'h0;
        bus.rs1_E      = 5'd0;
        bus.rs2_E      = 5'd0;
        bus.rd_E       = 5'd0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [3:0] op, input logic sa,
                             input logic sb, input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2,
                             input logic [31:0] imm, input logic [4:0] rd, input logic rw,
                             input logic [1:0] wb, input logic [2:0] br);
        bubble();
        bus.pc_E = pc;      bus.alu_op_E = op;   bus.sel_A_E = sa;   bus.sel_B_E = sb;
        bus.rs1_E = rs1;    bus.rs1_data_E = d1; bus.rs2_E = rs2;    bus.rs2_data_E = d2;
        bus.imm_E = imm;    bus.rd_E = rd;       bus.reg_wr_E = rw;  bus.wb_sel_E = wb;
        bus.br_type_E = br;
    endtask

    // Inputs are already applied (after a falling edge); check redirect, queue E/M.
    task automatic step(input string name, input logic exp_tk, input logic chk_tgt,
                        input logic [31:0] exp_tgt, input em_t exp_em);
        #1;
        check1({name, "_br_taken"}, {31'd0, bus.br_taken}, {31'd0, exp_tk});
        if (chk_tgt) check1({name, "_br_target"}, bus.br_target, exp_tgt);
        if (!rst && !bus.stall_M && bus.br_type_E != BR_NONE && bus.br_type_E != BR_JUMP)
            exp_branch_cnt++;
        if (exp_tk) exp_taken_cnt++;
        exp_q.push_back(exp_em);
        last_exp = exp_em;
        @(negedge clk);
    endtask

    logic [3:0]  t_op [12] = '{ALU_SLL, ALU_SRA, ALU_SRL, ALU_SLT, ALU_SLTU, ALU_AND,
                               ALU_OR, ALU_PASS_B, 4'd12, ALU_SUB, ALU_ADD, 4'd15};
    logic [31:0] t_a  [12] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'h1234,
                               32'h0, 32'hFFFF_FFFF, 32'hFFFF};
    logic [31:0] t_b  [12] = '{32'h24, 32'h4, 32'h4, 32'h1, 32'h1, 32'hFF00, 32'hFF00,
                               32'hFF00, 32'h5, 32'h1, 32'h2, 32'h1};
    logic [31:0] t_r  [12] = '{32'h10, 32'hF800_0000, 32'h0800_0000, 32'h1, 32'h0,
                               32'hF000, 32'hFFF0, 32'hFF00, 32'h0, 32'hFFFF_FFFF,
                               32'h1, 32'h0};

    initial begin
        bubble();
        bus.pc_E = 32'h0;  bus.stall_M = 1'b0;
        bus.rd_W = 5'd0;   bus.reg_wr_W = 1'b0;  bus.wb_data_W = 32'h0;
        @(negedge clk);

        // Reset with an equal-operand BEQ in E: no redirect, reset values.
        set_instr(32'h10, ALU_ADD, 1, 1, 5'd21, 32'h9, 5'd22, 32'h9, 32'h0, 5'd4, 1, WB_ALU, BR_EQ);
        step("rst0", 0, 0, 0, EM_RST);
        step("rst1", 0, 0, 0, EM_RST);
        rst = 1'b0;

        // ADDI x5,x0,7
        set_instr(32'h40, ALU_ADD, 1, 1, 5'd0, 32'h0, 5'd0, 32'h0, 32'd7, 5'd5, 1, WB_ALU, BR_NONE);
        step("addi_x5", 0, 1, 32'h6, '{32'd7, 32'h0, 32'h40, 5'd5, 1'b1, 3'd0, 3'd0, 2'd1});
        // ADD x6,x5,x5 with stale register-file data: both sources from M
        set_instr(32'h44, ALU_ADD, 1, 0, 5'd5, 32'h0, 5'd5, 32'h0, 32'h0, 5'd6, 1, WB_ALU, BR_NONE);
        step("add_fwd_m", 0, 1, 32'd14, '{32'd14, 32'd7, 32'h44, 5'd6, 1'b1, 3'd0, 3'd0, 2'd1});
        // ADDI x3,x0,1
        set_instr(32'h48, ALU_ADD, 1, 1, 5'd0, 32'h0, 5'd0, 32'h0, 32'd1, 5'd3, 1, WB_ALU, BR_NONE);
        step("addi_x3", 0, 0, 0, '{32'd1, 32'h0, 32'h48, 5'd3, 1'b1, 3'd0, 3'd0, 2'd1});
        // M (x3=1) beats W (x3=2) beats register file (0x55)
        bus.rd_W = 5'd3;  bus.reg_wr_W = 1'b1;  bus.wb_data_W = 32'd2;
        set_instr(32'h4C, ALU_ADD, 1, 0, 5'd3, 32'h55, 5'd0, 32'h0, 32'h0, 5'd7, 1, WB_ALU, BR_NONE);
        step("m_over_w", 0, 0, 0, '{32'd1, 32'h0, 32'h4C, 5'd7, 1'b1, 3'd0, 3'd0, 2'd1});
        // Write x0 in M and W; x0 readers must still see the register file.
        bus.rd_W = 5'd0;  bus.wb_data_W = 32'h77;
        set_instr(32'h50, ALU_ADD, 1, 1, 5'd0, 32'h0, 5'd0, 32'h0, 32'd9, 5'd0, 1, WB_ALU, BR_NONE);
        step("wr_x0", 0, 0, 0, '{32'd9, 32'h0, 32'h50, 5'd0, 1'b1, 3'd0, 3'd0, 2'd1});
        set_instr(32'h54, ALU_ADD, 1, 0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd8, 1, WB_ALU, BR_NONE);
        step("no_fwd_x0", 0, 0, 0, '{32'd0, 32'h0, 32'h54, 5'd8, 1'b1, 3'd0, 3'd0, 2'd1});
        // W-only forward on rs1, store-width pass-through
        bus.rd_W = 5'd10;  bus.wb_data_W = 32'h30;
        set_instr(32'h58, ALU_XOR, 1, 0, 5'd10, 32'h0, 5'd11, 32'h0F, 32'h0, 5'd9, 0, WB_ALU, BR_NONE);
        bus.wr_en_E = 3'd2;
        step("xor_fwd_w", 0, 0, 0, '{32'h3F, 32'h0F, 32'h58, 5'd9, 1'b0, 3'd2, 3'd0, 2'd1});
        // Load in M must not forward its address
        bus.reg_wr_W = 1'b0;
        set_instr(32'h5C, ALU_ADD, 1, 1, 5'd0, 32'h0, 5'd0, 32'h0, 32'h100, 5'd12, 1, WB_MEM, BR_NONE);
        bus.rd_en_E = 3'd2;
        step("load", 0, 0, 0, '{32'h100, 32'h0, 32'h5C, 5'd12, 1'b1, 3'd0, 3'd2, 2'd2});
        set_instr(32'h60, ALU_SUB, 1, 1, 5'd12, 32'h5, 5'd0, 32'h0, 32'd2, 5'd13, 1, WB_ALU, BR_NONE);
        step("no_fwd_load", 0, 0, 0, '{32'd3, 32'h0, 32'h60, 5'd13, 1'b1, 3'd0, 3'd0, 2'd1});

        // Branch comparator: -1 vs 1, then equal operands
        set_instr(32'h64, ALU_ADD, 0, 1, 5'd14, 32'hFFFF_FFFF, 5'd15, 32'd1, 32'h10, 5'd0, 0, WB_ALU, BR_LT);
        step("blt", 1, 1, 32'h74, '{32'h74, 32'd1, 32'h64, 5'd0, 1'b0, 3'd0, 3'd0, 2'd1});
        set_instr(32'h68, ALU_ADD, 0, 1, 5'd14, 32'hFFFF_FFFF, 5'd15, 32'd1, 32'h10, 5'd0, 0, WB_ALU, BR_LTU);
        step("bltu", 0, 0, 0, '{32'h78, 32'd1, 32'h68, 5'd0, 1'b0, 3'd0, 3'd0, 2'd1});
        set_instr(32'h6C, ALU_ADD, 0, 1, 5'd14, 32'hFFFF_FFFF, 5'd15, 32'd1, 32'h10, 5'd0, 0, WB_ALU, BR_GEU);
        step("bgeu", 1, 1, 32'h7C, '{32'h7C, 32'd1, 32'h6C, 5'd0, 1'b0, 3'd0, 3'd0, 2'd1});
        set_instr(32'h70, ALU_ADD, 0, 1, 5'd14, 32'hFFFF_FFFF, 5'd15, 32'd1, 32'h10, 5'd0, 0, WB_ALU, BR_GE);
        step("bge", 0, 0, 0, '{32'h80, 32'd1, 32'h70, 5'd0, 1'b0, 3'd0, 3'd0, 2'd1});
        set_instr(32'h74, ALU_ADD, 0, 1, 5'd14, 32'd1, 5'd15, 32'd1, 32'h10, 5'd0, 0, WB_ALU, BR_EQ);
        step("beq", 1, 1, 32'h84, '{32'h84, 32'd1, 32'h74, 5'd0, 1'b0, 3'd0, 3'd0, 2'd1});
        set_instr(32'h78, ALU_ADD, 0, 1, 5'd14, 32'd1, 5'd15, 32'd1, 32'h10, 5'd0, 0, WB_ALU, BR_NE);
        step("bne", 0, 0, 0, '{32'h88, 32'd1, 32'h78, 5'd0, 1'b0, 3'd0, 3'd0, 2'd1});
        // JALR x1,0(x16) with an odd target
        set_instr(32'h80, ALU_ADD, 1, 1, 5'd16, 32'h1003, 5'd0, 32'h0, 32'h0, 5'd1, 1, WB_PC4, BR_JUMP);
        step("jalr", 1, 1, 32'h1002, '{32'h1003, 32'h0, 32'h80, 5'd1, 1'b1, 3'd0, 3'd0, 2'd0});

        for (int i = 0; i < 12; i++) begin
            set_instr(32'h84 + 32'(i * 4), t_op[i], 1, 1, 5'd17, t_a[i], 5'd0, 32'h0, t_b[i],
                      5'd0, 0, WB_ALU, BR_NONE);
            step($sformatf("alu%0d", i), 0, 1, t_r[i] & 32'hFFFF_FFFE,
                 '{t_r[i], 32'h0, 32'h84 + 32'(i * 4), 5'd0, 1'b0, 3'd0, 3'd0, 2'd1});
        end

        // Stall with a jump in E: no redirect, E/M frozen while E changes
        bus.stall_M = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(32'hC0 + 32'(i * 4), ALU_ADD, 0, 1, 5'd0, 32'h0, 5'd0, 32'h0, 32'd8,
                      5'd2 + 5'(i), 1, WB_PC4, BR_JUMP);
            step($sformatf("stall%0d", i), 0, 0, 0, last_exp);
        end
        bus.stall_M = 1'b0;
        set_instr(32'hCC, ALU_ADD, 1, 1, 5'd0, 32'h0, 5'd0, 32'h0, 32'h123, 5'd20, 1, WB_ALU, BR_NONE);
        step("unstall", 0, 1, 32'h122, '{32'h123, 32'h0, 32'hCC, 5'd20, 1'b1, 3'd0, 3'd0, 2'd1});

        // Reset mid-run, asserted together with a stall and a taken BEQ
        rst = 1'b1;  bus.stall_M = 1'b1;
        set_instr(32'hD0, ALU_ADD, 1, 1, 5'd21, 32'h9, 5'd22, 32'h9, 32'h4, 5'd23, 1, WB_ALU, BR_EQ);
        step("rst_mid", 0, 0, 0, EM_RST);
        rst = 1'b0;  bus.stall_M = 1'b0;
        bubble();
        bus.pc_E = 32'hD4;
        step("bubble", 0, 1, 32'hD4, '{32'hD4, 32'h0, 32'hD4, 5'd0, 1'b0, 3'd0, 3'd0, 2'd1});

        @(negedge clk);
        @(negedge clk);
        check1("queue_drain", 32'(exp_q.size()), 32'd0);
`ifdef EX_PERF_CNT_EN
        // Counters cleared by the mid-run reset; only the bubble follows it.
        check1("branch_cnt", branch_cnt, 32'd0);
        check1("taken_cnt", taken_cnt, 32'd0);
        if (exp_branch_cnt < 0 || exp_taken_cnt < 0) n_fail++;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32I 5-stage pipeline.
- Consumes the D/E control register outputs and the D/E data operands, applies M/W forwarding, runs the ALU and branch comparator, and drives the redirect/flush to fetch and to the D/E register.
- Holds the registered E/M pipeline register that feeds the memory stage.

Parameters:
XLEN, 32, datapath width
RESET_PC, 32'h0000_0000, value of pc_M after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_M  in  1  memory-stage wait; freezes E/M register
alu_op_E  in  4  ALU operation
reg_wr_E  in  1  register write enable
sel_A_E  in  1  1=rs1, 0=pc
sel_B_E  in  1  1=imm, 0=rs2
wr_en_E  in  3  store width code (pass-through)
rd_en_E  in  3  load width code (pass-through)
wb_sel_E  in  2  0=pc+4, 1=ALU, 2=mem
br_type_E  in  3  0 BEQ, 1 BNE, 2 none, 3 jump, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU
pc_E, rs1_data_E, rs2_data_E, imm_E  in  XLEN  operands
rs1_E, rs2_E, rd_E  in  5  register addresses
rd_W, reg_wr_W  in  5/1  writeback destination
wb_data_W  in  XLEN  writeback data
br_taken  out  1  combinational redirect; also drives D/E clr and F/D flush
br_target  out  XLEN  redirect PC, bit0 forced 0
alu_result_M, store_data_M, pc_M  out  XLEN  E/M register
rd_M  out  5  E/M register
reg_wr_M  out  1  E/M register
wr_en_M, rd_en_M  out  3  E/M register
wb_sel_M  out  2  E/M register

Behaviour:
- Reset: all E/M outputs 0, except pc_M=RESET_PC and wb_sel_M=1. Reset has priority over stall_M.
- Forwarding, combinational, per source independently:
  - src==rd_M && reg_wr_M && rd_M!=0 && wb_sel_M!=2 → use alu_result_M.
  - else src==rd_W && reg_wr_W && rd_W!=0 → use wb_data_W.
  - else use the register-file value.
  - M has priority over W. x0 is never forwarded. Load-use hazards are stalled upstream and are not handled here.
- Operand A = sel_A_E ? fwd_rs1 : pc_E.
- Operand B = sel_B_E ? imm_E : fwd_rs2.
- ALU op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
  - 11–15 produce 0.
  - Shift amount is B[4:0]. Add/sub wrap modulo 2^XLEN.
- Branch compare uses fwd_rs1 vs fwd_rs2 (signed for BLT/BGE, unsigned for BLTU/BGEU).
- br_type 3 is always taken. br_type 2 is never taken.
- br_target = alu_result & ~1.
- br_taken is forced 0 while stall_M=1, so no redirect fires while E is held.
- E/M register update:
  - Loads on every clk when !rst && !stall_M; one-cycle latency.
  - store_data_M = fwd_rs2.
  - pc_M = pc_E.
  - wb_sel_M=0 consumers use pc_M+4; that addition is done downstream.
- Stall: stall_M holds all E/M outputs unchanged. The upstream D/E register is held by the hazard unit.
- Bubble: a D/E no-op (reg_wr=0, wr_en=0, rd_en=0, br_type=2) passes through with no side effects and no forwarding match.
- Reset mid-operation: rst in any cycle clears the E/M register on that edge and suppresses br_taken in that cycle.

Optional Feature:
- Macro EX_PERF_CNT_EN.
- When defined, adds output ports branch_cnt and taken_cnt (32 bits each, reset 0, wrap-around).
  - branch_cnt increments each unstalled cycle with br_type_E∉{2,3}.
  - taken_cnt increments each cycle br_taken=1.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Package rv32_pkg holds:
  - ALU_* op codes (4-bit).
  - BR_* types (3-bit, BR_NONE=2, BR_JUMP=3).
  - WB_PC4/WB_ALU/WB_MEM (2-bit).
- Sub-module rv32_alu: combinational, inputs op, a, b; output result.
- Forwarding, branch compare and the E/M register remain in ex_stage.

Test Plan:
- ADD with forward-from-M: prior instruction writes x5=7 (alu_result_M=7, rd_M=5); ADD x6,x5,x5 with stale rs1/rs2_data=0 → alu_result_M=14 next cycle.
- M/W priority: rd_M=rd_W=3, alu_result_M=1, wb_data_W=2; rs1_E=3 → operand uses 1. With rd_M=0 and rs1_E=0 → no forward; the register-file value (0) is used.
- BLT signed: rs1=0xFFFF_FFFF, rs2=1, br_type=4 → br_taken=1. Same operands with BLTU (6) → br_taken=0.
- JALR: sel_A=1, sel_B=1, rs1=0x1003, imm=0, br_type=3 → br_target=0x1002, br_taken=1.
- Stall: with stall_M=1 for 3 cycles while E inputs change and br_type_E=3 → E/M outputs constant and br_taken=0. On release, the next edge loads the current E values.
- Reset: rst=1 during an active BEQ (operands equal) → br_taken=0, all E/M outputs at reset values, wb_sel_M=1, pc_M=RESET_PC.
